// File: rtl/apb_rtc_alarm_bank_if.sv
// APB slave bundle for the RTC alarm bank: request fields from the master,
// zero-wait-state response fields from the slave.
interface apb_rtc_alarm_bank_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_rtc_alarm_bank.sv
// Seconds counter with a prescaler and NUM_ALARMS compare channels behind APB;
// sticky hit status, maskable level interrupt, one-shot or periodic channels.
module apb_rtc_alarm_bank #(
   parameter int NUM_ALARMS = 4,
   parameter int PRESCALE   = 100
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   apb_rtc_alarm_bank_if.slave   apb,
   output logic [NUM_ALARMS-1:0] o_alarm_hit,
   output logic                  o_irq
);

   localparam int PW        = $clog2(PRESCALE);
   localparam int LAST_WORD = 5 + 2 * (NUM_ALARMS - 1);

   logic                  run;
   logic                  irq_en;
   logic [31:0]           time_q;
   logic [PW-1:0]         presc;
   logic [NUM_ALARMS-1:0] status;
   logic [NUM_ALARMS-1:0] mask;
   logic [NUM_ALARMS-1:0] en;
   logic [NUM_ALARMS-1:0] periodic;
   logic [31:0]           cmp    [NUM_ALARMS];
   logic [15:0]           period [NUM_ALARMS];

   logic                  access;
   logic                  mapped;
   logic                  wr_en;
   logic [5:0]            word;
   logic                  wr_ctrl, wr_time, wr_status, wr_mask;
   logic [NUM_ALARMS-1:0] wr_cmp, wr_cfg, hit, reload;
   logic                  tick;
   logic [31:0]           time_inc;
   logic [31:0]           rd_mux;
   logic                  unused_ok;

   // Reset gates the access phase so a transfer in flight during reset is dropped.
   assign access    = apb.psel & apb.penable & i_rst_n;
   assign word      = apb.paddr[7:2];
   assign mapped    = (word <= 6'(LAST_WORD));
   assign wr_en     = access & apb.pwrite & mapped;
   assign wr_ctrl   = wr_en & (word == 6'd0);
   assign wr_time   = wr_en & (word == 6'd1);
   assign wr_status = wr_en & (word == 6'd2);
   assign wr_mask   = wr_en & (word == 6'd3);
   assign unused_ok = &{1'b0, apb.paddr[1:0]};

   assign tick     = run & (presc == PW'(PRESCALE - 1));
   assign time_inc = time_q + 32'd1;

   always_comb begin
      rd_mux = '0;
      wr_cmp = '0;
      wr_cfg = '0;
      hit    = '0;
      reload = '0;
      case (word)
         6'd0:    rd_mux = {30'd0, irq_en, run};
         6'd1:    rd_mux = time_q;
         6'd2:    rd_mux = 32'(status);
         6'd3:    rd_mux = 32'(mask);
         default: rd_mux = '0;
      endcase
      for (int i = 0; i < NUM_ALARMS; i++) begin
         wr_cmp[i] = wr_en & (word == 6'(4 + 2 * i));
         wr_cfg[i] = wr_en & (word == 6'(5 + 2 * i));
         // A software TIME write replaces the increment, so it cannot produce a hit.
         hit[i]    = tick & ~wr_time & en[i] & (time_inc == cmp[i]);
         reload[i] = periodic[i] & (period[i] != 16'd0);
         if (word == 6'(4 + 2 * i)) rd_mux = cmp[i];
         if (word == 6'(5 + 2 * i)) rd_mux = {period[i], 14'd0, periodic[i], en[i]};
      end
   end

   assign apb.pready  = access;
   assign apb.pslverr = access & ~mapped;
   assign apb.prdata  = (access & ~apb.pwrite) ? rd_mux : 32'd0;

   assign o_irq = irq_en & (|(status & mask));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         run         <= 1'b0;
         irq_en      <= 1'b0;
         time_q      <= '0;
         presc       <= '0;
         status      <= '0;
         mask        <= '0;
         en          <= '0;
         periodic    <= '0;
         o_alarm_hit <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            cmp[i]    <= '0;
            period[i] <= '0;
         end
      end else begin
         o_alarm_hit <= hit;
         if (wr_ctrl) begin
            run    <= apb.pwdata[0];
            irq_en <= apb.pwdata[1];
         end
         if (wr_time) begin
            time_q <= apb.pwdata;
            presc  <= '0;
         end else if (run) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) time_q <= time_inc;
         end
         if (wr_mask) mask <= apb.pwdata[NUM_ALARMS-1:0];
         // New hits are OR-ed in after the W1C so a same-edge set wins.
         status <= (status & ~(wr_status ? apb.pwdata[NUM_ALARMS-1:0] : '0)) | hit;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wr_cmp[i])
               cmp[i] <= apb.pwdata;
            else if (hit[i] & reload[i])
               cmp[i] <= cmp[i] + 32'(period[i]);
            if (wr_cfg[i]) begin
               en[i]       <= apb.pwdata[0];
               periodic[i] <= apb.pwdata[1];
               period[i]   <= apb.pwdata[31:16];
            end else if (hit[i] & ~reload[i]) begin
               en[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_rtc_alarm_bank.sv
// Directed and randomized APB traffic against the RTC alarm bank, checked each
// cycle against a behavioural model of the seconds counter and alarm channels.
module tb_apb_rtc_alarm_bank;
   localparam int NA = 4;
   localparam int PS = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [NA-1:0] o_alarm_hit;
   logic          o_irq;

   apb_rtc_alarm_bank_if apb();

   apb_rtc_alarm_bank #(.NUM_ALARMS(NA), .PRESCALE(PS)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .apb         (apb),
      .o_alarm_hit (o_alarm_hit),
      .o_irq       (o_irq)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit            m_run, m_irqen;
   logic [31:0]   m_time;
   int            m_cycles_in_second;
   logic [NA-1:0] m_status, m_mask, m_en, m_per, m_hit;
   logic [31:0]   m_cmp    [NA];
   logic [15:0]   m_period [NA];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_mapped(input logic [7:0] a);
      return int'(a[7:2]) < 4 + 2 * NA;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int w = int'(a[7:2]);
      int ch;
      if (w == 0) return {30'd0, m_irqen, m_run};
      if (w == 1) return m_time;
      if (w == 2) return 32'(m_status);
      if (w == 3) return 32'(m_mask);
      if (w < 4 + 2 * NA) begin
         ch = (w - 4) / 2;
         if (w % 2 == 0) return m_cmp[ch];
         return {m_period[ch], 14'd0, m_per[ch], m_en[ch]};
      end
      return 32'd0;
   endfunction

   function automatic logic m_irq();
      return m_irqen & (|(m_status & m_mask));
   endfunction

   // Advance one rising edge, update the model from the bus values present at that edge.
   task automatic clk_edge();
      bit            acc, wr, second_done, wt;
      int            w;
      logic [31:0]   d;
      logic [NA-1:0] hits;
      longint        sum;
      @(posedge i_clk);
      hits = '0;
      if (!i_rst_n) begin
         m_run = 0; m_irqen = 0; m_time = 0; m_cycles_in_second = 0;
         m_status = 0; m_mask = 0; m_en = 0; m_per = 0;
         for (int i = 0; i < NA; i++) begin
            m_cmp[i] = 0; m_period[i] = 0;
         end
      end else begin
         acc = apb.psel && apb.penable;
         wr  = acc && apb.pwrite && m_mapped(apb.paddr);
         w   = int'(apb.paddr[7:2]);
         d   = apb.pwdata;
         second_done = m_run && (m_cycles_in_second == PS - 1);
         wt  = wr && (w == 1);
         for (int i = 0; i < NA; i++)
            hits[i] = second_done && !wt && m_en[i] && (m_time + 32'd1 == m_cmp[i]);
         if (wt) begin
            m_time = d;
            m_cycles_in_second = 0;
         end else if (m_run) begin
            m_cycles_in_second = (m_cycles_in_second + 1) % PS;
            if (second_done) m_time = 32'((longint'(m_time) + 1) % 64'h1_0000_0000);
         end
         if (wr && w == 0) begin
            m_run = d[0]; m_irqen = d[1];
         end
         if (wr && w == 3) m_mask = d[NA-1:0];
         if (wr && w == 2) m_status = m_status & ~d[NA-1:0];
         m_status = m_status | hits;
         for (int i = 0; i < NA; i++) begin
            if (wr && w == 4 + 2 * i) m_cmp[i] = d;
            else if (hits[i] && m_per[i] && m_period[i] != 0) begin
               sum = (longint'(m_cmp[i]) + longint'(m_period[i])) % 64'h1_0000_0000;
               m_cmp[i] = 32'(sum);
            end
            if (wr && w == 5 + 2 * i) begin
               m_en[i] = d[0]; m_per[i] = d[1]; m_period[i] = d[31:16];
            end else if (hits[i] && !(m_per[i] && m_period[i] != 0)) begin
               m_en[i] = 0;
            end
         end
      end
      m_hit = hits;
      #1;
      check("alarm_hit", 32'(o_alarm_hit), 32'(m_hit));
      check("irq", 32'(o_irq), 32'(m_irq()));
   endtask

   task automatic idle(input int n);
      apb.psel = 0; apb.penable = 0;
      for (int i = 0; i < n; i++) clk_edge();
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = a; apb.pwdata = d;
      clk_edge();
      apb.penable = 1;
      #1;
      check("wr_pready", 32'(apb.pready), 32'd1);
      check("wr_pslverr", 32'(apb.pslverr), 32'(!m_mapped(a)));
      clk_edge();
      apb.psel = 0; apb.penable = 0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      apb.psel = 1; apb.penable = 0; apb.pwrite = 0; apb.paddr = a;
      clk_edge();
      apb.penable = 1;
      #1;
      d = apb.prdata;
      check("rd_pready", 32'(apb.pready), 32'd1);
      check("rd_pslverr", 32'(apb.pslverr), 32'(!m_mapped(a)));
      check("rd_data", d, m_read(a));
      clk_edge();
      apb.psel = 0; apb.penable = 0;
   endtask

   task automatic read_all();
      logic [31:0] d;
      for (int w = 0; w < 4 + 2 * NA; w++) apb_read(8'(w * 4), d);
   endtask

   initial begin
      logic [31:0] d;
      int          op;
      logic [7:0]  a;
      apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 0; apb.pwdata = 0;

      // Reset and basic counting
      i_rst_n = 0;
      idle(3);
      i_rst_n = 1;
      read_all();
      apb_write(8'h00, 32'h1);
      idle(4);
      apb_read(8'h04, d);
      check("time_after_4", d, 32'd1);
      idle(14);
      apb_read(8'h04, d);
      check("time_after_20", d, 32'd5);

      // One-shot channel 0 with interrupt
      apb_write(8'h00, 32'h0);
      apb_write(8'h04, 32'h0);
      apb_write(8'h0C, 32'h1);
      apb_write(8'h10, 32'd3);
      apb_write(8'h14, 32'h1);
      apb_write(8'h00, 32'h3);
      idle(16);
      check("irq_oneshot", 32'(o_irq), 32'd1);
      apb_read(8'h08, d);
      check("status_oneshot", d, 32'h1);
      apb_read(8'h14, d);
      check("cfg0_cleared", d, 32'h0);
      apb_write(8'h08, 32'h1);
      check("irq_cleared", 32'(o_irq), 32'd0);

      // Periodic channel 1
      apb_write(8'h00, 32'h0);
      apb_write(8'h04, 32'h0);
      apb_write(8'h18, 32'd2);
      apb_write(8'h1C, 32'h0003_0003);
      apb_write(8'h0C, 32'h2);
      apb_write(8'h00, 32'h1);
      idle(34);
      apb_write(8'h00, 32'h0);
      apb_read(8'h18, d);
      check("cmp1_reloaded", d, 32'd11);
      apb_read(8'h1C, d);
      check("cfg1_kept", d, 32'h0003_0003);

      // Wrap-around hit on channel 2, then a direct TIME write that must not hit
      apb_write(8'h08, 32'hF);
      apb_write(8'h04, 32'hFFFF_FFFE);
      apb_write(8'h20, 32'd0);
      apb_write(8'h24, 32'h1);
      apb_write(8'h00, 32'h1);
      idle(10);
      apb_write(8'h00, 32'h0);
      apb_read(8'h08, d);
      check("wrap_hit", d & 32'h4, 32'h4);
      apb_write(8'h08, 32'hF);
      apb_write(8'h20, 32'h50);
      apb_write(8'h24, 32'h1);
      apb_write(8'h04, 32'h50);
      idle(3);
      apb_read(8'h08, d);
      check("time_write_no_hit", d, 32'h0);
      apb_write(8'h24, 32'h0);

      // TIME write colliding with a tick
      apb_write(8'h04, 32'h0);
      apb_write(8'h00, 32'h1);
      idle(2);
      apb_write(8'h04, 32'h100);
      idle(2);
      apb_read(8'h04, d);
      check("time_write_wins", d, 32'h100);
      apb_read(8'h04, d);
      check("time_next_inc", d, 32'h101);

      // W1C colliding with a new hit on the same bit
      apb_write(8'h00, 32'h0);
      apb_write(8'h04, 32'h0);
      apb_write(8'h08, 32'hF);
      apb_write(8'h28, 32'd1);
      apb_write(8'h2C, 32'h0001_0003);
      apb_write(8'h00, 32'h1);
      idle(6);
      apb_write(8'h08, 32'h8);
      apb_read(8'h08, d);
      check("w1c_set_wins", d & 32'h8, 32'h8);
      apb_write(8'h00, 32'h0);
      apb_write(8'h2C, 32'h0);

      // Unmapped address
      apb_read(8'(8'h0C + 8 * NA + 8'h10), d);
      check("unmapped_rd", d, 32'h0);
      apb_write(8'(8'h0C + 8 * NA + 8'h10), 32'hFFFF_FFFF);
      read_all();

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 9));
         if (op < 2) begin
            idle(int'($urandom_range(1, 6)));
         end else if (op < 4) begin
            a = 8'($urandom_range(0, 63) * 4);
            apb_read(a, d);
         end else begin
            a = 8'($urandom_range(0, 4 + 2 * NA - 1) * 4);
            case (int'(a[7:2]))
               0:       d = {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
               1:       d = m_time + 32'($urandom_range(0, 3)) - 32'd2;
               2, 3:    d = 32'($urandom_range(0, 15));
               default: if (a[2] == 1'b0) d = m_time + 32'($urandom_range(1, 4));
                        else d = {16'($urandom_range(0, 3)), 14'd0, 2'($urandom_range(0, 3))};
            endcase
            if ($urandom_range(0, 15) == 0) a = 8'($urandom_range(4 + 2 * NA, 63) * 4);
            apb_write(a, d);
         end
      end
      read_all();

      // Reset during an access phase drops the transfer
      apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = 8'h00; apb.pwdata = 32'h3;
      clk_edge();
      apb.penable = 1;
      i_rst_n = 0;
      clk_edge();
      check("pready_in_reset", 32'(apb.pready), 32'd0);
      apb.psel = 0; apb.penable = 0;
      i_rst_n = 1;
      read_all();
      apb_read(8'h00, d);
      check("ctrl_after_reset", d, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
